// File: rtl/pipe_stage_skid.sv
// Two-entry pipeline stage (main + skid) carrying a data payload and a control bundle.
// Latency: 1 cycle from accept into an empty stage to out_valid.
// Backpressure: in_ready = !skid_valid, which is registered, so out_ready never reaches in_ready combinationally.
//
// Ports:
//   clk, rst              rising-edge clock; synchronous active-high reset
//   in_valid/in_ready     upstream handshake; in_data/in_ctrl carry the bundle
//   out_valid/out_ready   downstream handshake; out_data/out_ctrl present the main entry
//   flush                 drops held bundles and any bundle accepted in the same cycle
//   occ                   number of held bundles (0..2)
//   stall_cnt, cnt_clr    saturating count of back-pressured cycles; synchronous clear
module pipe_stage_skid #(
  parameter int DATA_W   = 96,
  parameter int CTRL_W   = 11,
  parameter int CLR_DATA = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              cnt_clr
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  logic accept;
  logic xfer;
  logic stall;

  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign xfer     = main_valid && out_ready;
  assign stall    = main_valid && !out_ready;

  // Bundle storage. The skid entry is only ever filled while main is full
  // and stalled, and it always drains into main first, preserving order.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
    end else if (flush) begin
      // A transfer in this cycle has already been seen by downstream; only
      // the held copies and any incoming bundle are dropped.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      // in_ready is low here, so no accept can happen.
      if (xfer) begin
        main_data  <= skid_data;
        main_ctrl  <= skid_ctrl;
        skid_valid <= 1'b0;
      end
    end else if (main_valid) begin
      if (xfer) begin
        if (accept) begin
          main_data <= in_data;
          main_ctrl <= in_ctrl;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_data  <= in_data;
        skid_ctrl  <= in_ctrl;
        skid_valid <= 1'b1;
      end
    end else if (accept) begin
      main_data  <= in_data;
      main_ctrl  <= in_ctrl;
      main_valid <= 1'b1;
    end
  end

  // Stall counter: clear wins over increment; flush leaves it alone.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign out_valid = main_valid;
  // Control is forced to zero on a bubble so stale write enables never leak.
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_data  = ((CLR_DATA != 0) && !main_valid) ? '0 : main_data;
  assign occ       = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  localparam int DATA_W = 96;
  localparam int CTRL_W = 11;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occ;
  logic [CNT_W-1:0]  stall_cnt;
  logic              cnt_clr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLR_DATA(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occ(occ), .stall_cnt(stall_cnt), .cnt_clr(cnt_clr)
  );

  typedef struct {
    logic        rst;
    logic        flush;
    logic        clr;
    logic        iv;
    logic [15:0] id;
    logic        ordy;
    logic        eir;
    logic        eov;
    logic [15:0] eod;
    logic [1:0]  eocc;
    logic [1:0]  ecnt;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic f, input logic c, input logic iv,
                              input logic [15:0] id, input logic ordy,
                              input logic eir, input logic eov, input logic [15:0] eod,
                              input logic [1:0] eocc, input logic [1:0] ecnt);
    vec_t v;
    v.rst = r; v.flush = f; v.clr = c; v.iv = iv; v.id = id; v.ordy = ordy;
    v.eir = eir; v.eov = eov; v.eod = eod; v.eocc = eocc; v.ecnt = ecnt;
    return v;
  endfunction

  // Payload is the 16-bit tag replicated across the full width.
  function automatic logic [DATA_W-1:0] rep(input logic [15:0] d);
    return {6{d}};
  endfunction

  function automatic logic [CTRL_W-1:0] ctl(input logic [15:0] d);
    return d[10:0] ^ 11'h2A5;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic c, input logic iv,
                       input logic [15:0] id, input logic ordy);
    @(negedge clk);
    rst = r; flush = f; cnt_clr = c; in_valid = iv;
    in_data = rep(id); in_ctrl = ctl(id); out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic eir, input logic eov,
                            input logic [15:0] eod, input logic [1:0] eocc, input logic [1:0] ecnt);
    chk({tag, ".in_ready"},  128'(in_ready),  128'(eir));
    chk({tag, ".out_valid"}, 128'(out_valid), 128'(eov));
    chk({tag, ".out_data"},  128'(out_data),  eov ? 128'(rep(eod)) : 128'(0));
    chk({tag, ".out_ctrl"},  128'(out_ctrl),  eov ? 128'(ctl(eod)) : 128'(0));
    chk({tag, ".occ"},       128'(occ),       128'(eocc));
    chk({tag, ".stall_cnt"}, 128'(stall_cnt), 128'(ecnt));
  endtask

  vec_t tbl[22];

  initial begin
    rst = 1'b1; flush = 1'b0; cnt_clr = 1'b0; in_valid = 1'b0;
    in_data = '0; in_ctrl = '0; out_ready = 1'b0;

    //               rst flush clr iv  id     ordy  ir  ov  od     occ  cnt
    tbl[0]  = mk(1'b1,1'b0,1'b0,1'b0,16'd0 ,1'b0, 1'b1,1'b0,16'd0 ,2'd0,2'd0); // reset
    tbl[1]  = mk(1'b0,1'b0,1'b0,1'b1,16'd1 ,1'b1, 1'b1,1'b1,16'd1 ,2'd1,2'd0); // stream
    tbl[2]  = mk(1'b0,1'b0,1'b0,1'b1,16'd2 ,1'b1, 1'b1,1'b1,16'd2 ,2'd1,2'd0);
    tbl[3]  = mk(1'b0,1'b0,1'b0,1'b1,16'd3 ,1'b1, 1'b1,1'b1,16'd3 ,2'd1,2'd0);
    tbl[4]  = mk(1'b0,1'b0,1'b0,1'b0,16'd0 ,1'b1, 1'b1,1'b0,16'd0 ,2'd0,2'd0); // drain
    tbl[5]  = mk(1'b0,1'b0,1'b0,1'b1,16'd10,1'b0, 1'b1,1'b1,16'd10,2'd1,2'd0); // load A
    tbl[6]  = mk(1'b0,1'b0,1'b0,1'b1,16'd11,1'b0, 1'b0,1'b1,16'd10,2'd2,2'd1); // B to skid
    tbl[7]  = mk(1'b0,1'b0,1'b0,1'b1,16'd12,1'b0, 1'b0,1'b1,16'd10,2'd2,2'd2); // refused
    tbl[8]  = mk(1'b0,1'b0,1'b0,1'b1,16'd12,1'b1, 1'b1,1'b1,16'd11,2'd1,2'd2); // A out, B up
    tbl[9]  = mk(1'b0,1'b0,1'b0,1'b0,16'd0 ,1'b1, 1'b1,1'b0,16'd0 ,2'd0,2'd2); // B out
    tbl[10] = mk(1'b0,1'b0,1'b1,1'b0,16'd0 ,1'b0, 1'b1,1'b0,16'd0 ,2'd0,2'd0); // cnt_clr
    tbl[11] = mk(1'b0,1'b0,1'b0,1'b1,16'd20,1'b0, 1'b1,1'b1,16'd20,2'd1,2'd0);
    tbl[12] = mk(1'b0,1'b0,1'b0,1'b1,16'd21,1'b0, 1'b0,1'b1,16'd20,2'd2,2'd1);
    tbl[13] = mk(1'b0,1'b1,1'b0,1'b1,16'd22,1'b0, 1'b1,1'b0,16'd0 ,2'd0,2'd2); // flush occ=2
    tbl[14] = mk(1'b0,1'b0,1'b0,1'b0,16'd0 ,1'b1, 1'b1,1'b0,16'd0 ,2'd0,2'd2); // 22 absent
    tbl[15] = mk(1'b0,1'b0,1'b0,1'b1,16'd30,1'b0, 1'b1,1'b1,16'd30,2'd1,2'd2);
    tbl[16] = mk(1'b0,1'b1,1'b0,1'b1,16'd31,1'b1, 1'b1,1'b0,16'd0 ,2'd0,2'd2); // flush+xfer+acc
    tbl[17] = mk(1'b0,1'b0,1'b0,1'b1,16'd40,1'b0, 1'b1,1'b1,16'd40,2'd1,2'd2);
    tbl[18] = mk(1'b0,1'b0,1'b0,1'b1,16'd41,1'b0, 1'b0,1'b1,16'd40,2'd2,2'd3);
    tbl[19] = mk(1'b0,1'b0,1'b0,1'b0,16'd0 ,1'b0, 1'b0,1'b1,16'd40,2'd2,2'd3); // saturated
    tbl[20] = mk(1'b1,1'b1,1'b0,1'b1,16'd42,1'b0, 1'b1,1'b0,16'd0 ,2'd0,2'd0); // rst beats flush
    tbl[21] = mk(1'b0,1'b0,1'b0,1'b0,16'd0 ,1'b1, 1'b1,1'b0,16'd0 ,2'd0,2'd0); // nothing held

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].rst, tbl[i].flush, tbl[i].clr, tbl[i].iv, tbl[i].id, tbl[i].ordy);
      expect_out($sformatf("vec%0d", i), tbl[i].eir, tbl[i].eov, tbl[i].eod,
                 tbl[i].eocc, tbl[i].ecnt);
    end

    // Stall counter saturation with a 2-bit counter, then clear during a stall.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'd50, 1'b0);
    expect_out("stall_load", 1'b1, 1'b1, 16'd50, 2'd1, 2'd0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
      expect_out($sformatf("stall%0d", k), 1'b1, 1'b1, 16'd50, 2'd1,
                 (k + 1 > 3) ? 2'd3 : 2'(k + 1));
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
    expect_out("clr_in_stall", 1'b1, 1'b1, 16'd50, 2'd1, 2'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    expect_out("stall_after_clr", 1'b1, 1'b1, 16'd50, 2'd1, 2'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
    expect_out("stall_drain", 1'b1, 1'b0, 16'd0, 2'd0, 2'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default 96: width of the data payload (e.g. RS1/RS2/IM bundle).
REQ-002 Parameter CTRL_W, default 11: width of the control-signal bundle.
REQ-003 Parameter CLR_DATA, default 0: when 1, out_data reads 0 whenever out_valid=0.
REQ-004 Parameter CNT_W, default 16: width of the stall counter.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 in_valid  input  1  upstream holds a valid bundle.
REQ-009 in_ready  output  1  stage can accept this cycle.
REQ-010 in_data  input  DATA_W  upstream data payload.
REQ-011 in_ctrl  input  CTRL_W  upstream control bundle.
REQ-012 flush  input  1  discard all held and incoming bundles.
REQ-013 out_valid  output  1  stage presents a valid bundle.
REQ-014 out_ready  input  1  downstream accepts this cycle.
REQ-015 out_data  output  DATA_W  presented data payload.
REQ-016 out_ctrl  output  CTRL_W  presented control bundle; all-zero on bubble.
REQ-017 occ  output  2  number of held bundles (0..2).
REQ-018 stall_cnt  output  CNT_W  count of back-pressured cycles.
REQ-019 cnt_clr  input  1  synchronous clear of stall_cnt.

Function
REQ-020 Storage SHALL be two entries: main (drives outputs) and skid (overflow), each with a valid bit; FIFO order preserved.
REQ-021 in_ready SHALL equal !skid_valid, a registered value with no combinational path from out_ready.
REQ-022 Accept SHALL occur when in_valid && in_ready; transfer SHALL occur when out_valid && out_ready.
REQ-023 out_valid SHALL equal main_valid; out_ctrl SHALL be 0 when main_valid=0, so a bubble never asserts write enables downstream.
REQ-024 Main empty, accept: bundle enters main; out_valid rises next cycle (latency 1).
REQ-025 Main full, transfer and accept, skid empty: new bundle replaces main; occ stays 1.
REQ-026 Main full, no transfer, accept: bundle enters skid; in_ready is 0 next cycle; occ=2.
REQ-027 Skid full, transfer: skid moves to main, skid clears, in_ready is 1 next cycle.
REQ-028 Main full, transfer, no accept, skid empty: main clears; occ=0.
REQ-029 Held bundles SHALL NOT change while out_valid && !out_ready (stable presentation).
REQ-030 flush SHALL take priority over all events: next cycle main_valid=skid_valid=0, an accept in the flush cycle is discarded, in_ready=1.
REQ-031 A transfer occurring in the flush cycle SHALL still count as delivered to downstream.
REQ-032 stall_cnt SHALL increment on each cycle with out_valid && !out_ready, saturating at 2^CNT_W-1.
REQ-033 cnt_clr SHALL zero stall_cnt next cycle, winning over a simultaneous increment; flush SHALL NOT affect stall_cnt.
REQ-034 occ SHALL equal main_valid + skid_valid.

Reset
REQ-035 On rst: main_valid=0, skid_valid=0, stored data/ctrl=0, stall_cnt=0.
REQ-036 Outputs the cycle after rst: in_ready=1, out_valid=0, out_ctrl=0, out_data=0, occ=0, stall_cnt=0.
REQ-037 rst mid-operation SHALL discard held bundles, with priority over flush, accept and cnt_clr.

Verification
REQ-038 Streaming: in_valid=1, out_ready=1, data 1,2,3,... -> out_data 1,2,3 one cycle later, occ=1, stall_cnt=0.
REQ-039 Back-pressure: load A, B with out_ready=0 -> occ=2, in_ready=0, out_data=A stable; raise out_ready -> A then B, in_ready=1 after A leaves.
REQ-040 Flush while occ=2 with in_valid=1 -> next cycle out_valid=0, occ=0, out_ctrl=0, in_ready=1; the flushed input never appears.
REQ-041 Stall counter: CNT_W=2, out_valid=1, out_ready=0 for 5 cycles -> stall_cnt 1,2,3,3,3; cnt_clr with stall -> 0.
REQ-042 rst asserted with occ=2 and flush=1 -> all outputs at reset values next cycle; no held data emerges.
REQ-043 Bubble: CLR_DATA=1, out_valid=0 -> out_data=0 and out_ctrl=0 every such cycle.
